uart_tx_scheduler: RTL and testbench

//  Shares one UartTransmitter among NUM_REQ requesters (keypad, loopback echo, status reporter, ...).

---
 rtl/uart_tx_scheduler_pkg.sv | 20 ++
 rtl/uart_tx_scheduler_if.sv | 18 +
 rtl/uart_tx_scheduler_rr_arbiter.sv | 38 +++
 rtl/uart_tx_scheduler.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// uart_tx_scheduler_pkg : FSM state encoding and width helper for the scheduler
// Revision: 1.0
// ============================================================================
package uart_tx_scheduler_pkg;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_GAP       = 3'd4;

  // A width of at least one bit, so single-entry ranges still get a signal.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
// uart_tx_scheduler_if : write/in/busy/done/tx_error pins of one UART transmitter
// Revision: 1.0
// ============================================================================
interface uart_tx_scheduler_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_in;
  logic                 tx_write;
  logic                 tx_busy;
  logic                 tx_done;
  logic                 tx_error;

  modport master (output tx_in, tx_write, input tx_busy, tx_done, tx_error);
  modport slave  (input tx_in, tx_write, output tx_busy, tx_done, tx_error);
endinterface
`default_nettype wire

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// uart_tx_scheduler_rr_arbiter : combinational round-robin pick after last_grant
// Revision: 1.0
// ============================================================================
module uart_tx_scheduler_rr_arbiter
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last_grant,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [IDW-1:0]     grant_idx,
  output logic               grant_any
);

  logic [IDW-1:0] w_cand;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    w_cand    = '0;
    // Search starts one past the previous winner and wraps, so last_grant ranks lowest.
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_cand = IDW'((int'(last_grant) + off) % NUM_REQ);
      if (!grant_any && req[w_cand]) begin
        grant_any        = 1'b1;
        grant_idx        = w_cand;
        grant_oh[w_cand] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// uart_tx_scheduler : round-robin sharing of one UART transmitter among requesters
// Revision: 1.0
// ============================================================================
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_BITS     = 8,
  parameter int START_TIMEOUT = 64,
  parameter int GAP_CYCLES    = 2,
  parameter int CNT_W         = 16,
  localparam int IDW          = clog2_min1(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         cpl_valid,
  output logic [IDW-1:0]               cpl_id,
  output logic                         cpl_err,
  uart_tx_scheduler_if.master          tx,
  output logic                         active,
  output logic [CNT_W-1:0]             frame_count
);

  localparam int TO_W  = clog2_min1(START_TIMEOUT);
  localparam int GAP_W = clog2_min1(GAP_CYCLES);
  localparam logic [GAP_W-1:0] c_gap_last = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [2:0]           state_q, state_d;
  logic [IDW-1:0]       last_grant_q, last_grant_d;
  logic [DATA_BITS-1:0] tx_in_q, tx_in_d;
  logic                 tx_write_q, tx_write_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic                 cpl_valid_q, cpl_valid_d;
  logic [IDW-1:0]       cpl_id_q, cpl_id_d;
  logic                 cpl_err_q, cpl_err_d;
  logic [CNT_W-1:0]     frame_count_q, frame_count_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;

  logic [NUM_REQ-1:0]   w_grant_oh;
  logic [IDW-1:0]       w_grant_idx;
  logic                 w_grant_any;
  logic                 w_finish;
  logic                 w_fin_err;
  logic                 w_to_hit;
  logic [DATA_BITS-1:0] w_req_byte [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_req_byte[gi] = req_data[gi*DATA_BITS +: DATA_BITS];
  end

  uart_tx_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant_oh   (w_grant_oh),
    .grant_idx  (w_grant_idx),
    .grant_any  (w_grant_any)
  );

  // Fires while the counter steps to START_TIMEOUT-1, so the registered error
  // completion lands START_TIMEOUT cycles after the tx_write pulse.
  assign w_to_hit = (int'(to_cnt_q) + 1 >= START_TIMEOUT - 1);

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    tx_in_d       = tx_in_q;
    tx_write_d    = 1'b0;
    req_ready_d   = '0;
    cpl_valid_d   = 1'b0;
    cpl_id_d      = '0;
    cpl_err_d     = 1'b0;
    frame_count_d = frame_count_q;
    to_cnt_d      = to_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    w_finish      = 1'b0;
    w_fin_err     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_grant_any) begin
          state_d      = S_LOAD;
          tx_in_d      = w_req_byte[w_grant_idx];
          tx_write_d   = 1'b1;
          req_ready_d  = w_grant_oh;
          last_grant_d = w_grant_idx;
        end
      end
      S_LOAD: begin
        state_d  = S_WAIT_BUSY;
        to_cnt_d = '0;
      end
      S_WAIT_BUSY: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (tx.tx_done || tx.tx_error) begin
          w_finish  = 1'b1;
          w_fin_err = tx.tx_error;
        end else if (tx.tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (w_to_hit) begin
          w_finish  = 1'b1;
          w_fin_err = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (tx.tx_done || tx.tx_error) begin
          w_finish  = 1'b1;
          w_fin_err = tx.tx_error;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == c_gap_last) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (w_finish) begin
      cpl_valid_d = 1'b1;
      cpl_id_d    = last_grant_q;
      cpl_err_d   = w_fin_err;
      gap_cnt_d   = '0;
      state_d     = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      if (!w_fin_err) begin
        frame_count_d = frame_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      last_grant_q  <= IDW'(NUM_REQ - 1);
      tx_in_q       <= '0;
      tx_write_q    <= 1'b0;
      req_ready_q   <= '0;
      cpl_valid_q   <= 1'b0;
      cpl_id_q      <= '0;
      cpl_err_q     <= 1'b0;
      frame_count_q <= '0;
      to_cnt_q      <= '0;
      gap_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      tx_in_q       <= tx_in_d;
      tx_write_q    <= tx_write_d;
      req_ready_q   <= req_ready_d;
      cpl_valid_q   <= cpl_valid_d;
      cpl_id_q      <= cpl_id_d;
      cpl_err_q     <= cpl_err_d;
      frame_count_q <= frame_count_d;
      to_cnt_q      <= to_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign cpl_valid   = cpl_valid_q;
  assign cpl_id      = cpl_id_q;
  assign cpl_err     = cpl_err_q;
  assign tx.tx_in    = tx_in_q;
  assign tx.tx_write = tx_write_q;
  assign active      = (state_q != S_IDLE);
  assign frame_count = frame_count_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_scheduler : directed table, corner sequences and random frames
// Revision: 1.0
// ============================================================================
module tb_uart_tx_scheduler;

  localparam int NUM_REQ       = 4;
  localparam int DATA_BITS     = 8;
  localparam int START_TIMEOUT = 64;
  localparam int GAP_CYCLES    = 2;
  localparam int CNT_W         = 4;   // small counter so wrap-around is reachable

  localparam int M_NORMAL   = 0;      // busy for a while, then done
  localparam int M_FAST     = 1;      // done without busy ever rising
  localparam int M_ERR      = 2;      // busy, then tx_error alone
  localparam int M_DONE_ERR = 3;      // busy, then done and error together
  localparam int M_TIMEOUT  = 4;      // transmitter never answers

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] data;
    int          mode;
    int          d1;
    int          d2;
    int          id;
    logic [7:0]  dat;
    logic        err;
    logic [3:0]  cnt;
  } vec_t;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*DATA_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         cpl_valid;
  logic [1:0]                   cpl_id;
  logic                         cpl_err;
  logic                         active;
  logic [CNT_W-1:0]             frame_count;

  uart_tx_scheduler_if #(.DATA_BITS(DATA_BITS)) tx_if ();

  uart_tx_scheduler #(
    .NUM_REQ       (NUM_REQ),
    .DATA_BITS     (DATA_BITS),
    .START_TIMEOUT (START_TIMEOUT),
    .GAP_CYCLES    (GAP_CYCLES),
    .CNT_W         (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .cpl_valid   (cpl_valid),
    .cpl_id      (cpl_id),
    .cpl_err     (cpl_err),
    .tx          (tx_if),
    .active      (active),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  wire [31:0] w_outs = {10'd0, req_ready, cpl_valid, cpl_id, cpl_err, tx_if.tx_in,
                        tx_if.tx_write, active, frame_count};

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int rdy1_cnt = 0;
  int cpl1_cnt = 0;
  int m_last = 3;
  logic [3:0] m_cnt = '0;

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (req_ready[1]) rdy1_cnt <= rdy1_cnt + 1;
    if (cpl_valid && cpl_id == 2'd1) cpl1_cnt <= cpl1_cnt + 1;
  end

  // Transmitter model, configured per frame before the grant.
  int   xm_mode = M_NORMAL;
  int   xm_d1 = 0;
  int   xm_d2 = 1;
  logic xm_busy = 1'b0;

  task automatic xstep();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int mode_l;
    int d2_l;
    tx_if.tx_busy  = 1'b0;
    tx_if.tx_done  = 1'b0;
    tx_if.tx_error = 1'b0;
    forever begin
      xstep();
      if (tx_if.tx_write) begin
        xm_busy = 1'b1;
        mode_l  = xm_mode;
        d2_l    = xm_d2;
        repeat (xm_d1) xstep();
        if (mode_l != M_TIMEOUT) begin
          if (mode_l != M_FAST) begin
            tx_if.tx_busy = 1'b1;
            repeat (d2_l) xstep();
            tx_if.tx_busy = 1'b0;
          end
          tx_if.tx_done  = (mode_l == M_NORMAL || mode_l == M_FAST || mode_l == M_DONE_ERR);
          tx_if.tx_error = (mode_l == M_ERR || mode_l == M_DONE_ERR);
          xstep();
          tx_if.tx_done  = 1'b0;
          tx_if.tx_error = 1'b0;
        end
        xm_busy = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (req_ready == '0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("grant_seen", 32'(req_ready != '0), 32'd1);
  endtask

  task automatic wait_cpl();
    int n;
    n = 0;
    while (!cpl_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("cpl_seen", 32'(cpl_valid), 32'd1);
  endtask

  // Round-robin reference: first pending requester after the previous winner.
  function automatic int rr_pick(input logic [3:0] mask, input int last);
    int idx;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (last + k) % NUM_REQ;
      if (mask[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic run_frame(input logic [3:0] mask, input logic [31:0] data, input int mode,
                           input int d1, input int d2, input int exp_id,
                           input logic [7:0] exp_dat, input logic exp_err,
                           input logic [3:0] exp_cnt);
    int t_w;
    xm_mode   = mode;
    xm_d1     = d1;
    xm_d2     = d2;
    req_data  = data;
    req_valid = mask;
    wait_ready();
    chk("req_ready_onehot", 32'(req_ready), 32'(4'b0001 << exp_id));
    chk("tx_write_pulse", 32'(tx_if.tx_write), 32'd1);
    chk("tx_in_load", 32'(tx_if.tx_in), 32'(exp_dat));
    t_w = cycle;
    req_valid = '0;
    wait_cpl();
    chk("cpl_id", 32'(cpl_id), 32'(exp_id));
    chk("cpl_err", 32'(cpl_err), 32'(exp_err));
    chk("frame_count", 32'(frame_count), 32'(exp_cnt));
    chk("tx_in_hold", 32'(tx_if.tx_in), 32'(exp_dat));
    if (mode == M_TIMEOUT) chk("timeout_latency", 32'(cycle - t_w), 32'(START_TIMEOUT));
    m_last = exp_id;
    m_cnt  = exp_cnt;
  endtask

  vec_t tbl[11];

  initial begin
    int n;
    int id;
    int mode;
    int r;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        err;
    logic [3:0]  start_cnt;
    int          r1;
    int          c1;

    for (int i = 0; i < 5; i++)
      tbl[i] = '{4'hF, 32'h13121110, M_NORMAL, 0, 3, i % 4, 8'(8'h10 + i % 4), 1'b0, 4'(i + 1)};
    tbl[5]  = '{4'b0001, 32'h000000A5, M_NORMAL,   2, 10, 0, 8'hA5, 1'b0, 4'd6};
    tbl[6]  = '{4'b0100, 32'h44332211, M_TIMEOUT,  0, 0,  2, 8'h33, 1'b1, 4'd6};
    tbl[7]  = '{4'b1000, 32'h44332211, M_NORMAL,   1, 4,  3, 8'h44, 1'b0, 4'd7};
    tbl[8]  = '{4'b0010, 32'h44332211, M_DONE_ERR, 1, 3,  1, 8'h22, 1'b1, 4'd7};
    tbl[9]  = '{4'b1111, 32'h44332211, M_ERR,      0, 2,  2, 8'h33, 1'b1, 4'd7};
    tbl[10] = '{4'b1001, 32'h44332211, M_FAST,     2, 0,  3, 8'h44, 1'b0, 4'd8};

    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", w_outs, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++)
      run_frame(tbl[i].mask, tbl[i].data, tbl[i].mode, tbl[i].d1, tbl[i].d2,
                tbl[i].id, tbl[i].dat, tbl[i].err, tbl[i].cnt);

    // Requester 1 raises and withdraws valid while requester 0's frame is in flight.
    r1 = rdy1_cnt;
    c1 = cpl1_cnt;
    xm_mode = M_NORMAL; xm_d1 = 1; xm_d2 = 8;
    req_data = 32'h00005A3C;
    req_valid = 4'b0001;
    wait_ready();
    chk("drop_grant0", 32'(req_ready), 32'h1);
    req_valid = 4'b0010;
    repeat (3) @(negedge clk);
    req_valid = '0;
    wait_cpl();
    chk("drop_cpl_id", 32'(cpl_id), 32'd0);
    repeat (10) @(negedge clk);
    chk("dropped_never_ready", 32'(rdy1_cnt), 32'(r1));
    chk("dropped_never_cpl", 32'(cpl1_cnt), 32'(c1));
    chk("idle_after_drop", 32'(active), 32'd0);
    m_last = 0;
    m_cnt  = m_cnt + 1'b1;

    // Reset pulse while the scheduler sits in WAIT_DONE.
    xm_mode = M_NORMAL; xm_d1 = 1; xm_d2 = 20;
    req_data = 32'h44332211;
    req_valid = 4'b0100;
    wait_ready();
    chk("pre_reset_grant", 32'(req_ready), 32'(4'b0100));
    req_valid = '0;
    repeat (5) @(negedge clk);
    chk("active_mid_frame", 32'(active), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_frame_reset", w_outs, 32'd0);
    rst = 1'b0;
    m_last = 3;
    m_cnt  = '0;
    n = 0;
    while (xm_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    run_frame(4'b1001, 32'h44332211, M_NORMAL, 1, 2, 0, 8'h11, 1'b0, 4'd1);
    run_frame(4'b0100, 32'h44332211, M_NORMAL, 0, 2, 2, 8'h33, 1'b0, 4'd2);

    // Sixteen good frames bring a 4-bit frame_count back to where it started.
    start_cnt = m_cnt;
    for (int i = 0; i < 16; i++)
      run_frame(4'b0001, 32'h000000C3, M_FAST, 1, 0, 0, 8'hC3, 1'b0, 4'(m_cnt + 1));
    chk("frame_count_wrap", 32'(frame_count), 32'(start_cnt));

    for (int i = 0; i < 30; i++) begin
      mask = 4'($urandom_range(1, 15));
      data = $urandom;
      r = $urandom_range(0, 15);
      mode = (r == 0) ? M_TIMEOUT : (r <= 2) ? M_ERR : (r == 3) ? M_DONE_ERR :
             (r <= 6) ? M_FAST : M_NORMAL;
      id  = rr_pick(mask, m_last);
      err = (mode == M_TIMEOUT || mode == M_ERR || mode == M_DONE_ERR);
      run_frame(mask, data, mode, (mode == M_FAST) ? 1 + $urandom_range(0, 3) : $urandom_range(0, 3),
                $urandom_range(1, 6), id, 8'(data >> (8 * id)), err,
                err ? m_cnt : 4'(m_cnt + 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire
